// File: rtl/bp_lce_resp_arbiter.sv
// N-source LCE response merger: per-source FIFOs feed a single registered
// valid/ready output, arbitrated by fixed priority (with starvation guard) or round-robin.
module bp_lce_resp_arbiter #(
  parameter int num_src_p    = 2,
  parameter int resp_width_p = 96,
  parameter int els_p        = 2,
  parameter int arb_mode_p   = 0,
  parameter int max_wait_p   = 4,
  localparam int src_width_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_src_p*resp_width_p-1:0] resp_i,
  input  logic [num_src_p-1:0]              resp_v_i,
  output logic [num_src_p-1:0]              resp_ready_o,
  output logic [resp_width_p-1:0]           lce_resp_o,
  output logic                              lce_resp_v_o,
  input  logic                              lce_resp_ready_i,
  output logic [src_width_lp-1:0]           lce_resp_src_o,
  output logic                              idle_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0]     ptr_last_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0]     cnt_full_lp = cnt_w_lp'(els_p);
  localparam logic [src_width_lp-1:0] src_last_lp = src_width_lp'(num_src_p - 1);

  logic [resp_width_p-1:0] r_mem  [num_src_p][els_p];
  logic [ptr_w_lp-1:0]     r_wptr [num_src_p];
  logic [ptr_w_lp-1:0]     r_rptr [num_src_p];
  logic [cnt_w_lp-1:0]     r_cnt  [num_src_p];

  logic                    r_out_v;
  logic [resp_width_p-1:0] r_out_data;
  logic [src_width_lp-1:0] r_out_src;

  logic [num_src_p-1:0]    w_hv;
  logic [num_src_p-1:0]    w_full;
  logic [num_src_p-1:0]    w_ready;
  logic [num_src_p-1:0]    w_enq;
  logic [num_src_p-1:0]    w_deq;
  logic                    w_load;
  logic                    w_gnt_v;
  logic [src_width_lp-1:0] w_gnt_idx;

  always_comb begin
    w_hv   = '0;
    w_full = '0;
    for (int unsigned i = 0; i < num_src_p; i++) begin
      w_hv[i]   = (r_cnt[i] != '0);
      w_full[i] = (r_cnt[i] == cnt_full_lp);
    end
  end

  // Ready depends only on FIFO occupancy (and reset), never on downstream ready.
  assign w_ready = ~w_full & {num_src_p{~reset_i}};
  assign w_enq   = resp_v_i & w_ready;
  assign w_load  = ~r_out_v | lce_resp_ready_i;
  assign w_gnt_v = |w_hv;

  always_comb begin
    w_deq = '0;
    if (w_load && w_gnt_v) w_deq[w_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < num_src_p; i++) begin
      if (w_enq[i]) r_mem[i][r_wptr[i]] <= resp_i[i*resp_width_p +: resp_width_p];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < num_src_p; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < num_src_p; i++) begin
        if (w_enq[i]) r_wptr[i] <= (r_wptr[i] == ptr_last_lp) ? '0 : r_wptr[i] + ptr_w_lp'(1);
        if (w_deq[i]) r_rptr[i] <= (r_rptr[i] == ptr_last_lp) ? '0 : r_rptr[i] + ptr_w_lp'(1);
        if (w_enq[i] && !w_deq[i])      r_cnt[i] <= r_cnt[i] + cnt_w_lp'(1);
        else if (!w_enq[i] && w_deq[i]) r_cnt[i] <= r_cnt[i] - cnt_w_lp'(1);
      end
    end
  end

  generate
    if (arb_mode_p == 0) begin : g_fixed
      if (max_wait_p > 0) begin : g_guard
        localparam int wait_w_lp = $clog2(max_wait_p + 1);
        localparam logic [wait_w_lp-1:0] wait_max_lp = wait_w_lp'(max_wait_p);

        logic [wait_w_lp-1:0] r_wait [num_src_p];
        logic [num_src_p-1:0] w_starved;
        logic [num_src_p-1:0] w_pick;

        always_comb begin
          w_starved = '0;
          for (int unsigned i = 0; i < num_src_p; i++)
            w_starved[i] = w_hv[i] & (r_wait[i] == wait_max_lp);
        end

        // Starved sources pre-empt the plain priority order; lowest index wins within a set.
        always_comb begin
          w_pick    = (|w_starved) ? w_starved : w_hv;
          w_gnt_idx = '0;
          for (int unsigned k = 0; k < num_src_p; k++)
            if (w_pick[num_src_p-1-k]) w_gnt_idx = src_width_lp'(num_src_p - 1 - k);
        end

        always_ff @(posedge clk_i) begin
          if (reset_i) begin
            for (int unsigned i = 0; i < num_src_p; i++) r_wait[i] <= '0;
          end else if (w_load && w_gnt_v) begin
            for (int unsigned i = 0; i < num_src_p; i++) begin
              if (w_gnt_idx == src_width_lp'(i))
                r_wait[i] <= '0;
              else if (w_hv[i] && r_wait[i] != wait_max_lp)
                r_wait[i] <= r_wait[i] + wait_w_lp'(1);
            end
          end
        end
      end else begin : g_plain
        always_comb begin
          w_gnt_idx = '0;
          for (int unsigned k = 0; k < num_src_p; k++)
            if (w_hv[num_src_p-1-k]) w_gnt_idx = src_width_lp'(num_src_p - 1 - k);
        end
      end
    end else begin : g_rr
      logic [src_width_lp-1:0] r_rr;

      function automatic int unsigned rot(input int unsigned base, input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= num_src_p) s = s - num_src_p;
        return s;
      endfunction

      // Scan from the far end of the search order so the entry nearest r_rr wins.
      always_comb begin
        w_gnt_idx = '0;
        for (int unsigned k = 0; k < num_src_p; k++)
          if (w_hv[rot(32'(r_rr), num_src_p - 1 - k)])
            w_gnt_idx = src_width_lp'(rot(32'(r_rr), num_src_p - 1 - k));
      end

      always_ff @(posedge clk_i) begin
        if (reset_i)
          r_rr <= '0;
        else if (w_load && w_gnt_v)
          r_rr <= (w_gnt_idx == src_last_lp) ? '0 : w_gnt_idx + src_width_lp'(1);
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_out_v    <= 1'b0;
      r_out_data <= '0;
      r_out_src  <= '0;
    end else if (w_load) begin
      r_out_v <= w_gnt_v;
      if (w_gnt_v) begin
        r_out_data <= r_mem[w_gnt_idx][r_rptr[w_gnt_idx]];
        r_out_src  <= w_gnt_idx;
      end
    end
  end

  assign resp_ready_o = w_ready;
  assign lce_resp_v_o = r_out_v & ~reset_i;
  assign lce_resp_o   = reset_i ? '0 : r_out_data;
  assign idle_o       = reset_i | (~|w_hv & ~r_out_v);

  generate
    if (num_src_p == 1) begin : g_src_tie
      assign lce_resp_src_o = '0;
    end else begin : g_src_reg
      assign lce_resp_src_o = reset_i ? '0 : r_out_src;
    end
  endgenerate

endmodule

// File: doc/bp_lce_resp_arbiter.md
Name: bp_lce_resp_arbiter

Overview:
- Parametrised N-source merger for LCE->CCE response packets. It replaces the fixed two-way combinational response mux in the LCE tops.
- Each source is buffered in its own small FIFO. Heads are arbitrated in fixed-priority or round-robin mode, with a starvation guard in fixed mode.
- The winner drives one registered valid/ready output toward the coherence network.
- Sits between the req/cmd engines (and future snoop/writeback engines) and lce_resp_o in the I$ and D$ LCEs.

Parameters:
- num_src_p, 2, number of response sources; legal range 1..8.
- resp_width_p, 96, width of one LCE response packet in bits, carried opaquely.
- els_p, 2, depth of each per-source FIFO; must be >= 2.
- arb_mode_p, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- max_wait_p, 4, fixed mode only: number of grants a waiting source tolerates before it is promoted; 0 disables the guard.

Ports:
- clk_i, input, 1, clock.
- reset_i, input, 1, synchronous active-high reset.
- resp_i, input, num_src_p*resp_width_p, source packets; source i occupies bits [i*resp_width_p +: resp_width_p].
- resp_v_i, input, num_src_p, per-source valid.
- resp_ready_o, output, num_src_p, per-source ready (valid/ready handshake).
- lce_resp_o, output, resp_width_p, merged packet.
- lce_resp_v_o, output, 1, merged valid.
- lce_resp_ready_i, input, 1, downstream ready.
- lce_resp_src_o, output, max(1,clog2(num_src_p)), index of the source of the packet on lce_resp_o.
- idle_o, output, 1, asserted when all FIFOs are empty and the output register is empty.

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Values while reset_i is high: resp_ready_o=0, lce_resp_v_o=0, lce_resp_src_o=0, lce_resp_o=0, idle_o=1.
- Reset mid-operation: all buffered and output packets are discarded. The round-robin pointer and all wait counters clear to 0.
- Input handshake:
  - resp_ready_o[i] = ~full[i]. There is no combinational path from lce_resp_ready_i to resp_ready_o.
  - An enqueue happens on a clock edge where resp_v_i[i] & resp_ready_o[i].
  - Enqueued data is visible at the FIFO head in the next cycle.
  - Enqueue and dequeue of the same FIFO in one cycle are allowed when the FIFO is non-empty. Count is unchanged.
  - When full, ready stays low; there is no bypass.
- Output register (single entry):
  - load_en = ~lce_resp_v_o | lce_resp_ready_i.
  - When load_en is high and any head is valid, the granted head is dequeued and loaded, and lce_resp_v_o=1 next cycle.
  - When load_en is high and no head is valid, lce_resp_v_o=0 next cycle.
  - While lce_resp_v_o & ~lce_resp_ready_i, lce_resp_o and lce_resp_src_o hold stable.
  - Throughput is 1 packet per cycle.
  - Minimum latency: handshake in cycle 0 -> lce_resp_v_o in cycle 2.
- Arbitration is combinational on the FIFO head valids and evaluated only when load_en is high.
- Fixed mode (arb_mode_p=0):
  - Each source has a wait counter wait_r[i], width clog2(max_wait_p+1).
  - On each grant to another source j != i while head i is valid, wait_r[i] increments and saturates at max_wait_p.
  - wait_r[i] clears when source i is granted.
  - Starved set = {i : head valid & wait_r[i]==max_wait_p}. If the set is non-empty, the lowest-index starved source wins. Otherwise the lowest-index valid source wins.
  - With max_wait_p=0, the counters are unused and arbitration is pure fixed priority.
- Round-robin mode (arb_mode_p=1):
  - The pointer rr_r holds the highest-priority index. The search order is rr_r, rr_r+1, ... modulo num_src_p.
  - On a grant to g, rr_r <= (g+1) mod num_src_p. rr_r is unchanged when there is no grant.
  - Wrap-around from num_src_p-1 to 0 is required.
- With num_src_p=1 the block degenerates to a FIFO plus output register. lce_resp_src_o is tied to 0.
- idle_o = all FIFOs empty & ~lce_resp_v_o, registered-state based, with no input dependence.
- Packet ordering is preserved per source. There is no ordering guarantee across sources beyond the arbitration policy.

Test Plan:
- Single source, fixed mode: source 1 sends A at cycle 0 while ready=1 -> lce_resp_v_o=1, lce_resp_o=A, lce_resp_src_o=1 in cycle 2; idle_o returns to 1 in cycle 3.
- Backpressure, els_p=2: hold lce_resp_ready_i=0 and source 0 sends 4 packets.
  - 1 packet fills the output register and 2 fill the FIFO; then resp_ready_o[0]=0 and the 4th is stalled.
  - lce_resp_o stays stable.
  - Release ready -> packets appear in order, one per cycle.
- Fixed mode with max_wait_p=2: sources 0 and 1 both stream continuously, ready=1 -> grant sequence 0,0,1,0,0,1,... and source 1 is never starved beyond 2 grants.
- Round-robin mode, num_src_p=4: all sources continuously valid -> lce_resp_src_o sequence 0,1,2,3,0,1,... If only sources 3 and 0 are valid, the sequence alternates 3,0 across the wrap.
- Reset with 2 packets buffered and the output valid: assert reset_i for 1 cycle -> next cycle lce_resp_v_o=0, idle_o=1, resp_ready_o all 1. No stale packet is ever emitted.
- Simultaneous enqueue/dequeue: source 0 FIFO holds 1 entry, ready=1, new packet offered every cycle -> steady 1 packet per cycle and resp_ready_o[0] never drops.
